// File: rtl/seq_serial_pkg.sv
// Shared types and line constants for the seq_serial transmitter/receiver pair.
package seq_serial_pkg;

  // Frame states; PARITY is only visited when parity is enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter covering 0..range-1, never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/seq_serial_bit_timer.sv
// Per-bit cycle counter: wraps 0..CLKS_PER_BIT-1 and flags the final cycle of a bit.
module seq_serial_bit_timer
  import seq_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic last_cycle
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Count cycles within a bit; clear holds the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign last_cycle = (count == LAST);

endmodule

// File: rtl/seq_serial_tx.sv
// Parallel-to-serial line transmitter: start, NBITS data (LSB first), optional
// even parity, stop. Each serial bit is held CLKS_PER_BIT cycles.
//
// Handshake: a frame is taken on a rising edge where in_val && in_rdy are both
// high; in_data is sampled only at that edge. in_rdy depends on state only
// (never on in_val), so the sender may hold in_val high to stream frames.
module seq_serial_tx
  import seq_serial_pkg::*;
#(
  parameter int NBITS        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_data,
  output logic             out,
  output logic             busy
);

  localparam int BW = cnt_width(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  // FSM state is a named state_t signal so checkers can bind to it directly.
  state_t           state, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_idx, bit_idx_d;
  logic             parity_q, parity_d;
  logic             out_q, out_d;
  logic             last_cycle;
  logic             accept;

  // The timer idles at zero in IDLE so the first START cycle starts counting from 0.
  seq_serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .last_cycle(last_cycle)
  );

  assign in_rdy = (state == IDLE) || ((state == STOP) && last_cycle);
  assign accept = in_val && in_rdy;
  assign busy   = (state != IDLE);
  assign out    = out_q;

  // Next-state, datapath and next line level; the line level is computed from
  // the state being entered so out is registered yet aligned with the state.
  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_idx_d = bit_idx;
    parity_d  = parity_q;
    out_d     = out_q;
    case (state)
      IDLE: begin
        out_d = LINE_IDLE;
        if (accept) begin
          state_d   = START;
          shift_d   = in_data;
          bit_idx_d = '0;
          parity_d  = 1'b0;
          out_d     = START_BIT;
        end
      end
      START: begin
        if (last_cycle) begin
          state_d = DATA;
          out_d   = shift_q[0];
        end
      end
      DATA: begin
        if (last_cycle) begin
          parity_d = parity_q ^ shift_q[0];
          if (bit_idx == LAST_BIT) begin
            bit_idx_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              out_d   = parity_d;
            end else begin
              state_d = STOP;
              out_d   = STOP_BIT;
            end
          end else begin
            bit_idx_d = bit_idx + BW'(1);
            shift_d   = shift_q >> 1;
            out_d     = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (last_cycle) begin
          state_d = STOP;
          out_d   = STOP_BIT;
        end
      end
      STOP: begin
        if (last_cycle) begin
          if (accept) begin
            state_d   = START;
            shift_d   = in_data;
            bit_idx_d = '0;
            parity_d  = 1'b0;
            out_d     = START_BIT;
          end else begin
            state_d = IDLE;
            out_d   = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = LINE_IDLE;
      end
    endcase
  end

  // State, shift register, parity accumulator and line register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_idx  <= '0;
      parity_q <= 1'b0;
      out_q    <= LINE_IDLE;
    end else begin
      state    <= state_d;
      shift_q  <= shift_d;
      bit_idx  <= bit_idx_d;
      parity_q <= parity_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_seq_serial_tx.sv
// Directed bench for seq_serial_tx: three instances cover the default
// configuration, parity disabled, and single-cycle bits with 4 data bits.
module tb_seq_serial_tx;

  logic       clk;
  logic       rst;
  logic       val_a, val_b, val_c;
  logic [7:0] data_a, data_b;
  logic [3:0] data_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       out_a, out_b, out_c;
  logic       busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_q[$];
  logic exp_rdy_q[$];

  seq_serial_tx #(.NBITS(8), .CLKS_PER_BIT(2), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .reset(rst), .in_val(val_a), .in_rdy(rdy_a),
    .in_data(data_a), .out(out_a), .busy(busy_a)
  );

  seq_serial_tx #(.NBITS(8), .CLKS_PER_BIT(2), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .reset(rst), .in_val(val_b), .in_rdy(rdy_b),
    .in_data(data_b), .out(out_b), .busy(busy_b)
  );

  seq_serial_tx #(.NBITS(4), .CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut_c (
    .clk(clk), .reset(rst), .in_val(val_c), .in_rdy(rdy_c),
    .in_data(data_c), .out(out_c), .busy(busy_c)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge (sample/drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      0: begin val_a = v; data_a = d[7:0]; end
      1: begin val_b = v; data_b = d[7:0]; end
      default: begin val_c = v; data_c = d[3:0]; end
    endcase
  endtask

  function automatic logic get_out(input int sel);
    return (sel == 0) ? out_a : (sel == 1) ? out_b : out_c;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
  endfunction

  // Reference model: per-cycle expected line level and in_rdy for one frame.
  task automatic build_frame(input logic [15:0] d, input int nb, input int cpb, input int pe);
    logic bits[$];
    logic par;
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pe != 0) bits.push_back(par);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int j = 0; j < cpb; j++) begin
        exp_q.push_back(bits[i]);
        exp_rdy_q.push_back(1'b0);
      end
    end
    exp_rdy_q[exp_rdy_q.size() - 1] = 1'b1;
  endtask

  // Compare n cycles against the scoreboard; optionally alter inputs mid-run.
  task automatic run_check(input int sel, input int n, input int chg_cyc,
                           input logic [15:0] chg_data, input int drop_cyc,
                           input logic [15:0] drop_data);
    logic e_out, e_rdy;
    for (int c = 0; c < n; c++) begin
      if (c == chg_cyc)  set_in(sel, 1'b1, chg_data);
      if (c == drop_cyc) set_in(sel, 1'b0, drop_data);
      e_out = exp_q.pop_front();
      e_rdy = exp_rdy_q.pop_front();
      chk($sformatf("out[%0d] c%0d", sel, c), 16'(get_out(sel)), 16'(e_out));
      chk($sformatf("busy[%0d] c%0d", sel, c), 16'(get_busy(sel)), 16'd1);
      chk($sformatf("rdy[%0d] c%0d", sel, c), 16'(get_rdy(sel)), 16'(e_rdy));
      tick();
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, " out"}, 16'(get_out(sel)), 16'd1);
    chk({tag, " busy"}, 16'(get_busy(sel)), 16'd0);
    chk({tag, " rdy"}, 16'(get_rdy(sel)), 16'd1);
  endtask

  // Accept one frame, scramble in_data after acceptance, check every cycle.
  task automatic send(input int sel, input logic [15:0] d, input int nb,
                      input int cpb, input int pe, input string tag);
    int len;
    len = (2 + nb + pe) * cpb;
    build_frame(d, nb, cpb, pe);
    chk({tag, " rdy_pre"}, 16'(get_rdy(sel)), 16'd1);
    set_in(sel, 1'b1, d);
    tick();
    set_in(sel, 1'b0, 16'($urandom_range(0, 65535)));
    run_check(sel, len, -1, 16'd0, -1, 16'd0);
    chk_idle(sel, {tag, " post"});
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 16'd0);
    set_in(1, 1'b0, 16'd0);
    set_in(2, 1'b0, 16'd0);

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b0;
    #1;
    chk("rst_async out", 16'(out_a), 16'd1);
    chk("rst_async busy", 16'(busy_a), 16'd0);
    chk("rst_async rdy_c", 16'(rdy_c), 16'd1);
    tick();
    tick();
    #3 rst = 1'b1;
    tick();
    chk_idle(0, "rel_a");
    chk_idle(1, "rel_b");
    chk_idle(2, "rel_c");

    // Single frames on the default configuration.
    send(0, 16'h00A5, 8, 2, 1, "a5");
    send(0, 16'h0001, 8, 2, 1, "par1");
    send(0, 16'h0000, 8, 2, 1, "par0");

    // No parity slot: 20-cycle frame.
    send(1, 16'h0001, 8, 2, 0, "nopar");

    // Single-cycle bits, 4 data bits: 0,1,1,0,1,1,1.
    send(2, 16'h000B, 4, 1, 1, "cpb1");

    // Back-to-back with in_val held: 0xFF then 0x00, data edits mid-frame ignored.
    build_frame(16'h00FF, 8, 2, 1);
    build_frame(16'h0000, 8, 2, 1);
    set_in(0, 1'b1, 16'h00FF);
    tick();
    run_check(0, 44, 3, 16'h0000, 23, 16'h00FF);
    chk_idle(0, "b2b post");

    // Reset during DATA bit 3 of 0x55.
    build_frame(16'h0055, 8, 2, 1);
    set_in(0, 1'b1, 16'h0055);
    tick();
    set_in(0, 1'b0, 16'h0055);
    run_check(0, 8, -1, 16'd0, -1, 16'd0);
    exp_q.delete();
    exp_rdy_q.delete();
    chk("midrst bit3", 16'(out_a), 16'd0);
    #2 rst = 1'b0;
    #1;
    chk("midrst out", 16'(out_a), 16'd1);
    chk("midrst busy", 16'(busy_a), 16'd0);
    chk("midrst rdy", 16'(rdy_a), 16'd1);
    tick();
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle(0, $sformatf("midrst idle%0d", k));
    end
    send(0, 16'h003C, 8, 2, 1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_serial_tx.md
Name: seq_serial_tx

Overview:
Parallel-to-serial 1-bit line transmitter. It is the driving end of the single-bit sequential links used throughout the seq_gates problem family: it produces the `d`-style serial bit stream that downstream 1-bit flops and serial receivers sample. Each frame accepted on a val/rdy input interface is sent as start bit, data bits (LSB first), optional even parity, then stop bit. Each bit is held for a fixed number of clock cycles.

Parameters:
- NBITS, 8, data bits per frame (legal range 1..16).
- CLKS_PER_BIT, 2, clock cycles each serial bit is held (legal range >= 1).
- PARITY_EN, 1, 1 = insert an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_val  input  1  in_data is valid.
- in_rdy  output  1  transmitter can accept a frame this cycle.
- in_data  input  NBITS  parallel word to transmit.
- out  output  1  serial line; idles high; registered.
- busy  output  1  a frame is in flight (any state other than IDLE).

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Reset (reset=0, asynchronous): state=IDLE, out=1, busy=0, shift register=0, counters=0. All of this takes effect immediately, without waiting for clk.
- in_rdy is combinational:
  - 1 in IDLE.
  - 1 in the last cycle of STOP (bit counter == CLKS_PER_BIT-1).
  - 0 otherwise.
- Handshake: a frame is accepted on a rising edge where in_val && in_rdy.
  - in_data is captured into the shift register at that edge.
  - Later changes to in_data are ignored.
- Latency: after the accepting edge, out=0 (START) from the next cycle. Transitions:
  - START lasts CLKS_PER_BIT cycles, then DATA.
  - DATA sends NBITS bits, LSB first, each for CLKS_PER_BIT cycles, then PARITY (or STOP if PARITY_EN=0).
  - PARITY drives the XOR of all captured data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP drives out=1 for CLKS_PER_BIT cycles, then IDLE, or START if a new frame was accepted in the final STOP cycle.
- Frame length: (2 + NBITS + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames:
  - A handshake in the last STOP cycle starts the next START with no idle gap.
  - With in_val held high, frames are sent continuously.
- in_val while busy and not in the final STOP cycle: no handshake, and no effect on the frame in flight.
- Counters: the cycle counter wraps 0..CLKS_PER_BIT-1 and the bit index covers 0..NBITS-1. Counter widths are $clog2 of the range, minimum 1 bit.
- busy=1 from the cycle after acceptance through the last STOP cycle. It stays 1 across back-to-back frames.
- Reset mid-frame: out returns to 1 immediately and the frame is dropped. After release, in_rdy=1 and nothing is re-sent.
- CLKS_PER_BIT=1: every state lasts exactly one cycle per bit. No extra cycles are allowed.

Decomposition:
- Shared package seq_serial_pkg holds:
  - typedef enum for the states (IDLE, START, DATA, PARITY, STOP).
  - Line constants: LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module: seq_serial_bit_timer.
  - Behaviour: CLKS_PER_BIT cycle counter with clear input and a last_cycle output.
  - Reuse: also used by the matching receiver.
- Top-level module holds the FSM, shift register, parity accumulator and output register.

Test Plan:
- Reset behaviour: assert reset=0 mid-cycle with no clk edge -> out=1, busy=0 immediately; after release, in_rdy=1.
- Single frame, in_data=0xA5, defaults: out sequence is 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop). Each bit is held 2 cycles, 22 cycles total. in_rdy=0 from cycle 1 to cycle 20, 1 in cycle 21.
- Parity value, in_data=0x01 -> parity bit 1; in_data=0x00 -> parity bit 0. With PARITY_EN=0 and 0x01, the frame is 20 cycles and has no parity slot.
- Back-to-back: in_val held high with 0xFF then 0x00 -> second start bit immediately follows the last stop cycle; busy stays 1 for 44 cycles; in_data changed mid-frame is ignored.
- Reset mid-frame: reset=0 during DATA bit 3 of 0x55 -> out=1 at once. After release, the line stays 1 and the next frame (0x3C) is sent intact.
- CLKS_PER_BIT=1, NBITS=4, in_data=0xB -> out is 0,1,1,0,1,1,1 over exactly 7 cycles.
